// File: rtl/trace_pkg.sv
// trace_pkg: shared constants, types and record packing for the commit trace transmitter
package trace_pkg;
   localparam int FRAME_LEN = 5;
   localparam int SEQ_W = 3;
   localparam int IDX_W = $clog2(FRAME_LEN);
   localparam int REC_W = 8 * FRAME_LEN;
   typedef enum logic {IDLE, SEND} state_t;
   function automatic logic [REC_W-1:0] make_record(input logic [SEQ_W-1:0] seq, input logic [4:0] rd, input logic [31:0] data);
      return {seq, rd, data};
   endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered count; a push into a full FIFO is taken only alongside a pop
module sync_fifo #(
   parameter int W = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [W-1:0]             wdata,
   output logic [W-1:0]             rdata,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   logic [W-1:0] mem [DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr;
   logic do_push, do_pop;
   assign full = count == CW'(DEPTH);
   assign empty = count == '0;
   assign do_pop = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rdata = mem[rd_ptr];
   // storage array, written only on an accepted push
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end
   // pointers and occupancy; simultaneous push and pop leave count unchanged
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
      end
   end
endmodule

// File: rtl/wb_commit_trace_tx.sv
// wb_commit_trace_tx: captures writeback register commits and streams them as 5-byte frames
module wb_commit_trace_tx import trace_pkg::*; #(
   parameter int DEPTH = 8,
   parameter bit DROP_R0 = 1'b1,
   parameter int CNT_W = 8
) (
   input  logic                     SYS_clk,
   input  logic                     SYS_reset,
   input  logic                     trace_en,
   input  logic                     clear_stats,
   input  logic                     WB_RegWrite_signal,
   input  logic [4:0]               WB_write_register,
   input  logic [31:0]              WB_write_data,
   output logic [7:0]               tx_data,
   output logic                     tx_valid,
   input  logic                     tx_ready,
   output logic                     tx_last,
   output logic                     overflow,
   output logic [CNT_W-1:0]         drop_cnt,
   output logic [$clog2(DEPTH):0]   fifo_level
);
   state_t state;
   logic [IDX_W-1:0] idx;
   logic [REC_W-1:0] frame, head;
   logic [SEQ_W-1:0] seq;
   logic qual, full, empty, pop, drop, last_hs;
   assign qual = WB_RegWrite_signal && trace_en && !(DROP_R0 && WB_write_register == 5'd0);
   assign last_hs = state == SEND && tx_ready && idx == IDX_W'(FRAME_LEN - 1);
   assign pop = !empty && (state == IDLE || last_hs);
   assign drop = qual && full && !pop;
   assign tx_data = frame[REC_W-1 -: 8];

   sync_fifo #(.W(REC_W), .DEPTH(DEPTH)) u_fifo (
      .clk(SYS_clk),
      .rst(SYS_reset),
      .push(qual),
      .pop(pop),
      .wdata(make_record(seq, WB_write_register, WB_write_data)),
      .rdata(head),
      .count(fifo_level),
      .full(full),
      .empty(empty)
   );

   // sequence advances on every qualifying commit so dropped records leave a visible gap
   always_ff @(posedge SYS_clk) begin
      if (SYS_reset) seq <= '0;
      else if (qual) seq <= seq + 1'b1;
   end

   // drop statistics; clear_stats takes priority over a same-cycle drop
   always_ff @(posedge SYS_clk) begin
      if (SYS_reset || clear_stats) begin
         overflow <= 1'b0;
         drop_cnt <= '0;
      end else if (drop) begin
         overflow <= 1'b1;
         if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
      end
   end

   // serializer: shifts the frame out MSB byte first, reloading straight from the FIFO after the last byte
   always_ff @(posedge SYS_clk) begin
      if (SYS_reset) begin
         state <= IDLE;
         idx <= '0;
         frame <= '0;
         tx_valid <= 1'b0;
         tx_last <= 1'b0;
      end else if (pop) begin
         state <= SEND;
         idx <= '0;
         frame <= head;
         tx_valid <= 1'b1;
         tx_last <= 1'b0;
      end else if (last_hs) begin
         state <= IDLE;
         frame <= '0;
         tx_valid <= 1'b0;
         tx_last <= 1'b0;
      end else if (state == SEND && tx_ready) begin
         idx <= idx + 1'b1;
         frame <= {frame[REC_W-9:0], 8'h00};
         tx_last <= idx == IDX_W'(FRAME_LEN - 2);
      end
   end
endmodule

// File: tb/tb_wb_commit_trace_tx.sv
// tb_wb_commit_trace_tx: directed and randomized checks of the commit trace transmitter against a queue model
module tb_wb_commit_trace_tx;
   localparam int DEPTH = 8;
   logic SYS_clk = 1'b0, SYS_reset = 1'b1, trace_en = 1'b0, clear_stats = 1'b0;
   logic WB_RegWrite_signal = 1'b0, tx_ready = 1'b0;
   logic [4:0] WB_write_register = '0;
   logic [31:0] WB_write_data = '0;
   logic [7:0] tx_data, drop_cnt;
   logic tx_valid, tx_last, overflow;
   logic [3:0] fifo_level;
   int checks = 0, errors = 0;

   wb_commit_trace_tx #(.DEPTH(DEPTH), .DROP_R0(1'b1), .CNT_W(8)) dut (
      .SYS_clk(SYS_clk), .SYS_reset(SYS_reset), .trace_en(trace_en), .clear_stats(clear_stats),
      .WB_RegWrite_signal(WB_RegWrite_signal), .WB_write_register(WB_write_register),
      .WB_write_data(WB_write_data), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .tx_last(tx_last), .overflow(overflow), .drop_cnt(drop_cnt), .fifo_level(fifo_level)
   );

   always #5 SYS_clk = ~SYS_clk;

   logic [39:0] mq[$];
   logic [7:0] mfb[$];
   logic [2:0] mseq = '0;
   logic mov = 1'b0;
   logic [7:0] mdc = '0;
   logic [8:0] got[$];

   always @(posedge SYS_clk) begin : ref_model
      logic qual, hs, pp, fl;
      logic [39:0] rec;
      if (SYS_reset) begin
         mq.delete();
         mfb.delete();
         mseq = '0;
         mov = 1'b0;
         mdc = '0;
      end else begin
         qual = WB_RegWrite_signal && trace_en && WB_write_register != 5'd0;
         fl = mq.size() == DEPTH;
         hs = mfb.size() > 0 && tx_ready;
         pp = mq.size() > 0 && (mfb.size() == 0 || (hs && mfb.size() == 1));
         if (hs) void'(mfb.pop_front());
         if (pp) begin
            rec = mq.pop_front();
            for (int i = 4; i >= 0; i--) mfb.push_back(rec[i*8 +: 8]);
         end
         if (qual && (!fl || pp)) mq.push_back({mseq, WB_write_register, WB_write_data});
         if (clear_stats) begin
            mov = 1'b0;
            mdc = '0;
         end else if (qual && fl && !pp) begin
            mov = 1'b1;
            if (mdc != 8'hFF) mdc = mdc + 8'd1;
         end
         if (qual) mseq = mseq + 3'd1;
      end
   end

   always @(posedge SYS_clk) begin
      if (!SYS_reset && tx_valid && tx_ready) got.push_back({tx_last, tx_data});
   end

   task automatic do_reset;
      @(negedge SYS_clk);
      SYS_reset = 1'b1;
      WB_RegWrite_signal = 1'b0;
      tx_ready = 1'b0;
      clear_stats = 1'b0;
      trace_en = 1'b1;
      @(negedge SYS_clk);
      SYS_reset = 1'b0;
   endtask

   task automatic test_reset;
      SYS_reset = 1'b1;
      repeat (2) @(negedge SYS_clk);
      checks++;
      if ({tx_valid, tx_last, tx_data} !== 10'd0) begin
         errors++;
         $display("FAIL reset_tx: valid=%b last=%b data=%h, want all 0", tx_valid, tx_last, tx_data);
      end
      checks++;
      if (fifo_level !== 4'd0) begin
         errors++;
         $display("FAIL reset_level: got %0d want 0", fifo_level);
      end
      checks++;
      if ({overflow, drop_cnt} !== 9'd0) begin
         errors++;
         $display("FAIL reset_stats: overflow=%b drop_cnt=%0d, want 0/0", overflow, drop_cnt);
      end
      SYS_reset = 1'b0;
   endtask

   task automatic test_single_frame;
      logic [7:0] exp_b [5];
      logic ev, el;
      logic [7:0] eb;
      exp_b = '{8'h09, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
      do_reset;
      tx_ready = 1'b1;
      WB_RegWrite_signal = 1'b1;
      WB_write_register = 5'd9;
      WB_write_data = 32'hDEADBEEF;
      for (int k = 1; k <= 8; k++) begin
         @(negedge SYS_clk);
         WB_RegWrite_signal = 1'b0;
         ev = k >= 2 && k <= 6;
         eb = 8'h00;
         if (ev) eb = exp_b[k-2];
         el = k == 6;
         checks++;
         if (tx_valid !== ev || (ev && (tx_data !== eb || tx_last !== el))) begin
            errors++;
            $display("FAIL single_frame cyc %0d: valid=%b data=%h last=%b, want valid=%b data=%h last=%b",
                     k, tx_valid, tx_data, tx_last, ev, eb, el);
         end
      end
   endtask

   task automatic test_backpressure;
      logic [3:0] pat;
      logic [4:0] r;
      logic [31:0] d;
      logic [39:0] rec;
      logic pv, pr, pl;
      logic [7:0] pd;
      pat = 4'b1001;
      do_reset;
      got.delete();
      r = 5'($urandom_range(31, 1));
      d = $urandom;
      rec = {3'd0, r, d};
      WB_RegWrite_signal = 1'b1;
      WB_write_register = r;
      WB_write_data = d;
      tx_ready = 1'b1;
      pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = 8'h00;
      for (int k = 0; k < 30; k++) begin
         @(negedge SYS_clk);
         WB_RegWrite_signal = 1'b0;
         if (pv && !pr) begin
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== pd || tx_last !== pl) begin
               errors++;
               $display("FAIL bp_hold cyc %0d: valid=%b data=%h last=%b, want 1 %h %b", k, tx_valid, tx_data, tx_last, pd, pl);
            end
         end
         tx_ready = pat[k % 4];
         pv = tx_valid; pd = tx_data; pl = tx_last; pr = tx_ready;
      end
      checks++;
      if (got.size() != 5) begin
         errors++;
         $display("FAIL bp_count: got %0d bytes want 5", got.size());
      end
      for (int i = 0; i < 5 && i < got.size(); i++) begin
         checks++;
         if (got[i] !== {i == 4, rec[(4-i)*8 +: 8]}) begin
            errors++;
            $display("FAIL bp_byte %0d: got %h want %h", i, got[i], {i == 4, rec[(4-i)*8 +: 8]});
         end
      end
   endtask

   task automatic test_seq_r0;
      logic [2:0] s;
      do_reset;
      tx_ready = 1'b1;
      got.delete();
      for (int i = 0; i < 11; i++) begin
         WB_RegWrite_signal = 1'b1;
         WB_write_register = (i == 4) ? 5'd0 : 5'd1;
         WB_write_data = $urandom;
         @(negedge SYS_clk);
         WB_RegWrite_signal = 1'b0;
         repeat (6) @(negedge SYS_clk);
      end
      repeat (8) @(negedge SYS_clk);
      checks++;
      if (got.size() != 50) begin
         errors++;
         $display("FAIL seq_frames: got %0d bytes want 50", got.size());
      end
      for (int f = 0; f < 10 && 5*f < got.size(); f++) begin
         s = 3'(f);
         checks++;
         if (got[5*f] !== {1'b0, s, 5'd1}) begin
            errors++;
            $display("FAIL seq_byte0 frame %0d: got %h want %h", f, got[5*f], {1'b0, s, 5'd1});
         end
      end
   endtask

   task automatic test_overflow;
      logic [2:0] s;
      do_reset;
      tx_ready = 1'b0;
      got.delete();
      for (int i = 0; i < 10; i++) begin
         WB_RegWrite_signal = 1'b1;
         WB_write_register = 5'(i + 1);
         WB_write_data = $urandom;
         @(negedge SYS_clk);
      end
      WB_RegWrite_signal = 1'b0;
      checks++;
      if (fifo_level !== 4'd8 || overflow !== 1'b1 || drop_cnt !== 8'd1) begin
         errors++;
         $display("FAIL ovf_stats: level=%0d overflow=%b drop_cnt=%0d, want 8 1 1", fifo_level, overflow, drop_cnt);
      end
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== 8'h01) begin
         errors++;
         $display("FAIL ovf_stall: valid=%b data=%h, want 1 01", tx_valid, tx_data);
      end
      tx_ready = 1'b1;
      repeat (50) @(negedge SYS_clk);
      checks++;
      if (got.size() != 45) begin
         errors++;
         $display("FAIL ovf_drain: got %0d bytes want 45", got.size());
      end
      for (int f = 0; f < 9 && 5*f < got.size(); f++) begin
         s = 3'(f);
         checks++;
         if (got[5*f] !== {1'b0, s, 5'(f + 1)}) begin
            errors++;
            $display("FAIL ovf_byte0 frame %0d: got %h want %h", f, got[5*f], {1'b0, s, 5'(f + 1)});
         end
      end
      got.delete();
      WB_RegWrite_signal = 1'b1;
      WB_write_register = 5'd5;
      @(negedge SYS_clk);
      WB_RegWrite_signal = 1'b0;
      repeat (8) @(negedge SYS_clk);
      checks++;
      if (got.size() != 5 || got[0] !== {1'b0, 3'd2, 5'd5}) begin
         errors++;
         $display("FAIL ovf_gap: bytes=%0d byte0=%h, want 5 bytes byte0 045", got.size(), got.size() ? got[0] : 9'h1FF);
      end
      tx_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         WB_RegWrite_signal = 1'b1;
         WB_write_register = 5'(i + 1);
         clear_stats = i == 9;
         @(negedge SYS_clk);
         if (i == 8) begin
            checks++;
            if (overflow !== 1'b1 || drop_cnt !== 8'd1 || fifo_level !== 4'd8) begin
               errors++;
               $display("FAIL ovf_prefill: overflow=%b drop_cnt=%0d level=%0d, want 1 1 8", overflow, drop_cnt, fifo_level);
            end
         end
      end
      clear_stats = 1'b0;
      checks++;
      if (overflow !== 1'b0 || drop_cnt !== 8'd0 || fifo_level !== 4'd8) begin
         errors++;
         $display("FAIL clear_wins: overflow=%b drop_cnt=%0d level=%0d, want 0 0 8", overflow, drop_cnt, fifo_level);
      end
      @(negedge SYS_clk);
      WB_RegWrite_signal = 1'b0;
      checks++;
      if (overflow !== 1'b1 || drop_cnt !== 8'd1) begin
         errors++;
         $display("FAIL drop_after_clear: overflow=%b drop_cnt=%0d, want 1 1", overflow, drop_cnt);
      end
      tx_ready = 1'b1;
      repeat (50) @(negedge SYS_clk);
   endtask

   task automatic test_saturate;
      do_reset;
      tx_ready = 1'b0;
      WB_RegWrite_signal = 1'b1;
      WB_write_register = 5'($urandom_range(31, 1));
      for (int n = 1; n <= 270; n++) begin
         WB_write_data = $urandom;
         @(negedge SYS_clk);
         if (n == 263) begin
            checks++;
            if (drop_cnt !== 8'd254) begin
               errors++;
               $display("FAIL sat_pre: drop_cnt=%0d want 254", drop_cnt);
            end
         end
      end
      WB_RegWrite_signal = 1'b0;
      checks++;
      if (drop_cnt !== 8'hFF || overflow !== 1'b1) begin
         errors++;
         $display("FAIL sat_hold: drop_cnt=%0d overflow=%b want 255 1", drop_cnt, overflow);
      end
   endtask

   task automatic test_back_to_back;
      logic [31:0] d [3];
      logic [39:0] rec;
      logic ev, el;
      logic [7:0] eb;
      int nv;
      do_reset;
      tx_ready = 1'b1;
      nv = 0;
      for (int i = 0; i < 3; i++) d[i] = $urandom;
      for (int k = 1; k <= 20; k++) begin
         WB_RegWrite_signal = k <= 3;
         WB_write_register = 5'(k + 9);
         WB_write_data = (k <= 3) ? d[k-1] : 32'h0;
         @(negedge SYS_clk);
         ev = k >= 2 && k <= 16;
         el = k == 6 || k == 11 || k == 16;
         eb = 8'h00;
         if (ev) begin
            rec = {3'((k - 2) / 5), 5'((k - 2) / 5 + 10), d[(k - 2) / 5]};
            eb = rec[(4 - (k - 2) % 5)*8 +: 8];
         end
         if (tx_valid) nv++;
         checks++;
         if (tx_valid !== ev || (ev && (tx_data !== eb || tx_last !== el))) begin
            errors++;
            $display("FAIL b2b cyc %0d: valid=%b data=%h last=%b, want %b %h %b", k, tx_valid, tx_data, tx_last, ev, eb, el);
         end
      end
      WB_RegWrite_signal = 1'b0;
      checks++;
      if (nv != 15) begin
         errors++;
         $display("FAIL b2b_count: %0d valid cycles want 15", nv);
      end
   endtask

   task automatic test_reset_mid;
      logic [31:0] d;
      d = $urandom;
      do_reset;
      tx_ready = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         WB_RegWrite_signal = k <= 2;
         WB_write_register = (k == 1) ? 5'd3 : 5'd4;
         WB_write_data = d;
         @(negedge SYS_clk);
      end
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== d[23:16]) begin
         errors++;
         $display("FAIL mid_byte2: valid=%b data=%h want 1 %h", tx_valid, tx_data, d[23:16]);
      end
      WB_RegWrite_signal = 1'b0;
      SYS_reset = 1'b1;
      @(negedge SYS_clk);
      SYS_reset = 1'b0;
      checks++;
      if ({tx_valid, tx_last, tx_data} !== 10'd0 || fifo_level !== 4'd0) begin
         errors++;
         $display("FAIL mid_abort: valid=%b last=%b data=%h level=%0d want all 0", tx_valid, tx_last, tx_data, fifo_level);
      end
      WB_RegWrite_signal = 1'b1;
      WB_write_register = 5'd7;
      @(negedge SYS_clk);
      WB_RegWrite_signal = 1'b0;
      @(negedge SYS_clk);
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== 8'h07) begin
         errors++;
         $display("FAIL mid_seq0: valid=%b data=%h want 1 07", tx_valid, tx_data);
      end
      repeat (6) @(negedge SYS_clk);
   endtask

   task automatic test_random;
      int p;
      logic ev;
      do_reset;
      for (int n = 0; n < 1500; n++) begin
         p = (n / 250) % 3;
         SYS_reset = $urandom_range(0, 199) == 0;
         WB_RegWrite_signal = p == 0 ? $urandom_range(0, 7) == 0 : p == 1 ? $urandom_range(0, 2) != 0 : $urandom_range(0, 2) == 0;
         WB_write_register = 5'($urandom_range(0, 31));
         WB_write_data = $urandom;
         trace_en = $urandom_range(0, 9) != 0;
         clear_stats = $urandom_range(0, 39) == 0;
         tx_ready = $urandom_range(0, 3) != 0;
         @(negedge SYS_clk);
         ev = mfb.size() != 0;
         checks++;
         if (tx_valid !== ev || (ev && (tx_data !== mfb[0] || tx_last !== (mfb.size() == 1))) ||
             fifo_level !== 4'(mq.size()) || overflow !== mov || drop_cnt !== mdc) begin
            errors++;
            $display("FAIL random cyc %0d: valid=%b data=%h last=%b level=%0d ovf=%b drops=%0d, want valid=%b data=%h last=%b level=%0d ovf=%b drops=%0d",
                     n, tx_valid, tx_data, tx_last, fifo_level, overflow, drop_cnt,
                     ev, ev ? mfb[0] : 8'h00, mfb.size() == 1, mq.size(), mov, mdc);
         end
      end
      SYS_reset = 1'b0;
      WB_RegWrite_signal = 1'b0;
      clear_stats = 1'b0;
   endtask

   initial begin
      test_reset;
      test_single_frame;
      test_backpressure;
      test_seq_r0;
      test_overflow;
      test_saturate;
      test_back_to_back;
      test_reset_mid;
      test_random;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
